// File: rtl/gpio_matrix_if.sv
// Register bus between a system master and gpio_matrix: word-addressed write
// and read strobes with write data. The registered read data leaves gpio_matrix
// on its own port so that it can float.
interface gpio_matrix_if;
  logic [31:0] sys_w_addr;
  logic [31:0] sys_r_addr;
  logic [31:0] sys_w_line;
  logic        sys_w;
  logic        sys_r;

  modport master (output sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r);
  modport slave  (input  sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r);
endinterface

// File: rtl/gpio_matrix.sv
// GPIO pin matrix: each pin is routed to one of NFUNC functions or left as an input.
// Define GPIO_MATRIX_IRQ_EN to build the edge-interrupt logic (enables, status, irq).
module gpio_matrix #(
  parameter int NPINS = 32,
  parameter int NFUNC = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire  [NPINS-1:0]       pins,
  input  logic [NFUNC*NPINS-1:0] func_out,
  input  logic [NFUNC*NPINS-1:0] func_dir,
  output logic [NFUNC*NPINS-1:0] func_in,
  output logic                   irq,
  input  logic [31:0]            addr,
  gpio_matrix_if.slave           bus,
  output wire  [31:0]            sys_r_line
);

  logic [3:0]       r_sel [NPINS];
  logic [NPINS-1:0] r_sync1;
  logic [NPINS-1:0] r_sync2;
  logic             r_rd_vld;
  logic [31:0]      r_rd_data;

  logic [NPINS-1:0] w_out;
  logic [NPINS-1:0] w_dir;
  logic [127:0]     w_ctrl_flat;
  logic             w_wsel;
  logic             w_rsel;
  logic [2:0]       w_woff;
  logic [2:0]       w_roff;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_wsel   = bus.sys_w && (bus.sys_w_addr[31:3] == addr[31:3]);
  assign w_rsel   = bus.sys_r && (bus.sys_r_addr[31:3] == addr[31:3]);
  assign w_woff   = bus.sys_w_addr[2:0];
  assign w_roff   = bus.sys_r_addr[2:0];
  assign w_unused = ^addr[2:0];

  // Per-pin routing: selectors past NFUNC land on zero-padded columns, so the pin is an input.
  for (genvar gi = 0; gi < NPINS; gi++) begin : g_pin
    logic [15:0] w_fo_col;
    logic [15:0] w_fd_col;
    for (genvar gf = 0; gf < 16; gf++) begin : g_col
      if (gf < NFUNC) begin : g_on
        assign w_fo_col[gf] = func_out[gf*NPINS+gi];
        assign w_fd_col[gf] = func_dir[gf*NPINS+gi];
      end else begin : g_off
        assign w_fo_col[gf] = 1'b0;
        assign w_fd_col[gf] = 1'b0;
      end
    end
    assign w_out[gi] = w_fo_col[r_sel[gi]];
    assign w_dir[gi] = w_fd_col[r_sel[gi]];
    assign pins[gi]  = w_dir[gi] ? w_out[gi] : 1'bz;
    for (genvar gf = 0; gf < NFUNC; gf++) begin : g_fin
      assign func_in[gf*NPINS+gi] = w_dir[gi] ? w_out[gi] : pins[gi];
    end
  end

  for (genvar gp = 0; gp < 32; gp++) begin : g_ctrl
    if (gp < NPINS) begin : g_have
      assign w_ctrl_flat[4*gp +: 4] = r_sel[gp];
    end else begin : g_absent
      assign w_ctrl_flat[4*gp +: 4] = 4'h0;
    end
  end

`ifdef GPIO_MATRIX_IRQ_EN
  logic [NPINS-1:0] r_prev;
  logic [NPINS-1:0] r_rise_en;
  logic [NPINS-1:0] r_fall_en;
  logic [NPINS-1:0] r_status;
  logic             r_irq;
  logic [NPINS-1:0] w_evt;
  logic [NPINS-1:0] w_clr;
  logic [NPINS-1:0] w_status_nxt;

  // A fresh edge event overrides a same-cycle W1C clear of its bit.
  assign w_evt        = (r_sync2 & ~r_prev & r_rise_en) | (~r_sync2 & r_prev & r_fall_en);
  assign w_clr        = (w_wsel && (w_woff == 3'd7)) ? bus.sys_w_line[NPINS-1:0] : {NPINS{1'b0}};
  assign w_status_nxt = (r_status & ~w_clr) | w_evt;

  // Edge history, interrupt enables, sticky status and the registered request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= {NPINS{1'b0}};
      r_rise_en <= {NPINS{1'b0}};
      r_fall_en <= {NPINS{1'b0}};
      r_status  <= {NPINS{1'b0}};
      r_irq     <= 1'b0;
    end else begin
      r_prev   <= r_sync2;
      r_status <= w_status_nxt;
      r_irq    <= |w_status_nxt;
      if (w_wsel && (w_woff == 3'd5)) begin
        r_rise_en <= bus.sys_w_line[NPINS-1:0];
      end
      if (w_wsel && (w_woff == 3'd6)) begin
        r_fall_en <= bus.sys_w_line[NPINS-1:0];
      end
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  // Register read mux over the pre-edge state.
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_roff)
      3'd0:    w_rdata = w_ctrl_flat[31:0];
      3'd1:    w_rdata = w_ctrl_flat[63:32];
      3'd2:    w_rdata = w_ctrl_flat[95:64];
      3'd3:    w_rdata = w_ctrl_flat[127:96];
      3'd4:    w_rdata[NPINS-1:0] = r_sync2;
`ifdef GPIO_MATRIX_IRQ_EN
      3'd5:    w_rdata[NPINS-1:0] = r_rise_en;
      3'd6:    w_rdata[NPINS-1:0] = r_fall_en;
      3'd7:    w_rdata[NPINS-1:0] = r_status;
`endif
      default: w_rdata = 32'h0000_0000;
    endcase
  end

  // Selectors, input synchroniser and read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPINS; i++) begin
        r_sel[i] <= 4'h0;
      end
      r_sync1   <= {NPINS{1'b0}};
      r_sync2   <= {NPINS{1'b0}};
      r_rd_vld  <= 1'b0;
      r_rd_data <= 32'h0000_0000;
    end else begin
      r_sync1   <= pins;
      r_sync2   <= r_sync1;
      r_rd_vld  <= w_rsel;
      r_rd_data <= w_rsel ? w_rdata : 32'h0000_0000;
      if (w_wsel && (w_woff[2] == 1'b0)) begin
        for (int i = 0; i < NPINS; i++) begin
          if ((i / 8) == int'(w_woff[1:0])) begin
            r_sel[i] <= bus.sys_w_line[4*(i%8) +: 4];
          end
        end
      end
    end
  end

  assign sys_r_line = r_rd_vld ? r_rd_data : 32'bz;

endmodule

// File: tb/tb_gpio_matrix.sv
// Randomised self-checking bench for gpio_matrix against a register/history model;
// a pull-up on sys_r_line makes the floating read bus observable as all ones.
module tb_gpio_matrix;
  localparam int NP = 32;
  localparam int NF = 4;
  localparam logic [31:0] BASE = 32'h0000_1238;
  localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst;
  wire  [NP-1:0]    pins;
  logic [NF*NP-1:0] func_out;
  logic [NF*NP-1:0] func_dir;
  logic [NF*NP-1:0] func_in;
  logic             irq;
  wire  [31:0]      sys_r_line;
  logic [NP-1:0]    tb_oe;
  logic [NP-1:0]    tb_val;

  gpio_matrix_if bus_if();
  pullup pu_rd (sys_r_line);

  for (genvar g = 0; g < NP; g++) begin : g_drv
    assign pins[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  gpio_matrix #(.NPINS(NP), .NFUNC(NF)) dut (
    .clk(clk), .rst(rst), .pins(pins), .func_out(func_out), .func_dir(func_dir),
    .func_in(func_in), .irq(irq), .addr(BASE), .bus(bus_if), .sys_r_line(sys_r_line)
  );

  always #5 clk = ~clk;

  // Reference state: selectors, enables, status, last three pin samples (newest first).
  logic [3:0]    m_sel [NP];
  logic [31:0]   m_rise, m_fall, m_stat;
  logic [NP-1:0] m_smp [3];
  logic          m_rd_vld, m_irq;
  logic [31:0]   m_rd;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_dir(int i);
    int s = int'(m_sel[i]);
    return (s < NF) ? func_dir[s*NP+i] : 1'b0;
  endfunction

  function automatic logic m_out(int i);
    int s = int'(m_sel[i]);
    return (s < NF) ? func_out[s*NP+i] : 1'b0;
  endfunction

  function automatic logic [NP-1:0] m_pins();
    logic [NP-1:0] p;
    for (int i = 0; i < NP; i++) p[i] = m_dir(i) ? m_out(i) : tb_val[i];
    return p;
  endfunction

  function automatic logic [NF*NP-1:0] m_fin();
    logic [NF*NP-1:0] r;
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < NP; i++) r[f*NP+i] = m_dir(i) ? m_out(i) : tb_val[i];
    return r;
  endfunction

  function automatic logic [31:0] m_reg(logic [2:0] off);
    logic [31:0] v = 32'h0;
    case (off)
      3'd0, 3'd1, 3'd2, 3'd3: for (int j = 0; j < 8; j++) v[4*j +: 4] = m_sel[8*int'(off)+j];
      3'd4: v = m_smp[1];
`ifdef GPIO_MATRIX_IRQ_EN
      3'd5: v = m_rise;
      3'd6: v = m_fall;
      3'd7: v = m_stat;
`endif
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_sel[i] = 4'h0;
    m_rise = 32'h0; m_fall = 32'h0; m_stat = 32'h0;
    for (int k = 0; k < 3; k++) m_smp[k] = '0;
    m_rd_vld = 1'b0; m_rd = 32'h0; m_irq = 1'b0;
  endtask

  task automatic apply_drv();
    for (int i = 0; i < NP; i++) tb_oe[i] = ~m_dir(i);
  endtask

  // One clock edge: predict from pre-edge state, advance the model, compare outputs.
  task automatic tick();
    logic [NP-1:0] smp_now, evt, clr;
    logic [2:0]    woff, roff;
    logic          wsel, rsel;
    logic [31:0]   rdv, wd;
    apply_drv();
    #1;
    smp_now = m_pins();
    wsel = bus_if.sys_w && (bus_if.sys_w_addr[31:3] == BASE[31:3]);
    rsel = bus_if.sys_r && (bus_if.sys_r_addr[31:3] == BASE[31:3]);
    woff = bus_if.sys_w_addr[2:0];
    roff = bus_if.sys_r_addr[2:0];
    wd   = bus_if.sys_w_line;
    rdv  = m_reg(roff);
    evt  = (m_smp[1] & ~m_smp[2] & m_rise) | (~m_smp[1] & m_smp[2] & m_fall);
    clr  = (wsel && woff == 3'd7) ? wd : 32'h0;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_rd_vld = rsel;
      m_rd     = rdv;
      if (wsel && woff < 3'd4)
        for (int j = 0; j < 8; j++) m_sel[8*int'(woff)+j] = wd[4*j +: 4];
`ifdef GPIO_MATRIX_IRQ_EN
      if (wsel && woff == 3'd5) m_rise = wd;
      if (wsel && woff == 3'd6) m_fall = wd;
      m_stat = (m_stat & ~clr) | evt;
      m_irq  = |m_stat;
`endif
      m_smp[2] = m_smp[1];
      m_smp[1] = m_smp[0];
      m_smp[0] = smp_now;
    end
    #1;
    apply_drv();
    #1;
    chk("rd_line", sys_r_line, m_rd_vld ? m_rd : FLOAT);
    chk("irq", irq, m_irq);
    chk("pins", pins, m_pins());
    chk("func_in", func_in, m_fin());
  endtask

  function automatic logic [31:0] baddr(logic hit, logic [2:0] off);
    logic [28:0] miss = 29'($urandom_range(1, 32'h1FFF_FFFF));
    return hit ? {BASE[31:3], off} : {BASE[31:3] ^ miss, off};
  endfunction

  task automatic cyc(input logic w, input logic [2:0] woff, input logic [31:0] wd,
                     input logic r, input logic [2:0] roff, input logic hit);
    bus_if.sys_w      = w;
    bus_if.sys_w_addr = baddr(hit, woff);
    bus_if.sys_w_line = wd;
    bus_if.sys_r      = r;
    bus_if.sys_r_addr = baddr(hit, roff);
    tick();
    bus_if.sys_w = 1'b0;
    bus_if.sys_r = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    func_out = '0; func_dir = '0; tb_val = '0; tb_oe = '1;
    bus_if.sys_w = 1'b0; bus_if.sys_r = 1'b0;
    bus_if.sys_w_addr = 32'h0; bus_if.sys_r_addr = 32'h0; bus_if.sys_w_line = 32'h0;
    tick();
    tick();
    chk("rst_rd_float", sys_r_line, FLOAT);
    chk("rst_irq", irq, 1'b0);
    rst = 1'b0;

    func_dir[NP-1:0] = '1;
    func_out[NP-1:0] = 32'hA5A5_A5A5;
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b1);
    chk("f0_pins", pins, 32'hA5A5_A5A5);
    for (int f = 0; f < NF; f++) chk("f0_func_in", func_in[f*NP +: NP], 32'hA5A5_A5A5);

    func_out[2*NP] = 1'b1; func_dir[2*NP] = 1'b1;
    func_out[3*NP+1] = 1'b1; func_dir[3*NP+1] = 1'b1;
    func_out[1] = 1'b0;
    cyc(1'b1, 3'd0, 32'h0000_0032, 1'b0, 3'd0, 1'b1);
    chk("sel23_pins", pins[1:0], 2'b11);
    tb_val[1] = 1'b0;
    cyc(1'b1, 3'd0, 32'h0000_00F0, 1'b0, 3'd0, 1'b1);
    chk("sel15_released", pins[1], 1'b0);
    chk("sel15_func_in", func_in[3*NP+1], 1'b0);

    cyc(1'b1, 3'd0, 32'h8765_4321, 1'b0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 1'b1);
    chk("ctrl0_read", sys_r_line, 32'h8765_4321);
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 1'b0);
    chk("miss_read_float", sys_r_line, FLOAT);

    for (int n = 0; n < 400; n++) begin
      func_out = {$urandom, $urandom, $urandom, $urandom};
      func_dir = {$urandom, $urandom, $urandom, $urandom};
      tb_val   = $urandom;
      rst      = ($urandom_range(0, 49) == 0);
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 7) != 0);
    end

    rst = 1'b1;
    func_out = '0; func_dir = '0; tb_val = '0;
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b1);
    rst = 1'b0;
`ifdef GPIO_MATRIX_IRQ_EN
    cyc(1'b1, 3'd5, 32'h0000_0008, 1'b0, 3'd0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b1);
    tb_val[3] = 1'b1;
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 3'd4, 1'b1);
    chk("pin_in3", sys_r_line[3], 1'b1);
    chk("rise_irq", irq, 1'b1);
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 1'b1);
    chk("rise_status", sys_r_line, 32'h0000_0008);
    tb_val[3] = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b1);
    tb_val[3] = 1'b1;
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b1);
    cyc(1'b1, 3'd7, 32'h0000_0008, 1'b0, 3'd0, 1'b1);
    chk("w1c_vs_event_irq", irq, 1'b1);
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 1'b1);
    chk("w1c_vs_event_status", sys_r_line, 32'h0000_0008);
    cyc(1'b1, 3'd7, 32'h0000_0008, 1'b0, 3'd0, 1'b1);
    chk("w1c_clear_irq", irq, 1'b0);
`else
    cyc(1'b1, 3'd5, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 3'd5, 1'b1);
    chk("no_irq_off5", sys_r_line, 32'h0);
    chk("no_irq_tied", irq, 1'b0);
`endif

    rst = 1'b1;
    cyc(1'b1, 3'd1, 32'h1111_1111, 1'b0, 3'd0, 1'b1);
    rst = 1'b0;
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 3'd1, 1'b1);
    chk("rst_drops_write", sys_r_line, 32'h0);
    chk("rst_irq_low", irq, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/gpio_matrix.md
GPIO_MATRIX -- requirements
Module: gpio_matrix

Interface
REQ-001 Parameter NPINS, default 32, pin count, legal range 1..32.
REQ-002 Parameter NFUNC, default 4, functions per pin, legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pins  inout  NPINS  pad lines.
REQ-006 func_out  input  NFUNC*NPINS  function output data; function f, pin i at bit f*NPINS+i.
REQ-007 func_dir  input  NFUNC*NPINS  function direction, same packing; 1 = out, 0 = in.
REQ-008 func_in  output  NFUNC*NPINS  function input data, same packing.
REQ-009 irq  output  1  level interrupt request.
REQ-010 addr  input  32  constant base word address; bits [2:0] ignored.
REQ-011 sys_w_addr, sys_r_addr  input  32  write and read word addresses.
REQ-012 sys_w_line  input  32  write data; sys_r_line  output  32  registered read data.
REQ-013 sys_w, sys_r  input  1  write and read strobes, one cycle each.

Function
REQ-014 Select when sys_x_addr[31:3] == addr[31:3]; offset = sys_x_addr[2:0].
REQ-015 Map: 0..3 CTRL0..CTRL3 (RW), 4 PIN_IN (RO), 5 IRQ_RISE_EN (RW), 6 IRQ_FALL_EN (RW), 7 IRQ_STATUS (W1C).
REQ-016 CTRLk holds 4-bit selector for pins 8k..8k+7, pin i at bits [4(i%8)+3 : 4(i%8)].
REQ-017 Selector s < NFUNC: pin drives func_out/func_dir of function s; s >= NFUNC: pin is input, never driven.
REQ-018 pins[i] = selected out value when selected dir = 1, else high-Z; combinational from control state.
REQ-019 func_in for every function, pin i = selected out value when driven, else pins[i]; combinational, zero latency.
REQ-020 Each pin passes a 2-flop synchroniser (sync2) and one history flop (prev).
REQ-021 PIN_IN bit i = sync2[i]; pin change sampled at edge N is readable from the PIN_IN value captured at edge N+1.
REQ-022 Rising event: sync2 = 1, prev = 0, RISE_EN bit set. Falling event: sync2 = 0, prev = 1, FALL_EN bit set. Either event sets IRQ_STATUS bit on the same edge.
REQ-023 W1C: bit set where sys_w_line = 1 clears that IRQ_STATUS bit. A new event on the same edge wins; the bit stays 1.
REQ-024 irq = OR of IRQ_STATUS[NPINS-1:0], driven from registered state.
REQ-025 Read: sys_r with selected address loads sys_r_line at that edge, valid the following cycle. Otherwise sys_r_line loads 32'bz.
REQ-026 Write: selected sys_w updates the register at that edge. Read of the same register on the same edge returns the old value.
REQ-027 Bits at or above NPINS, and CTRL fields for absent pins, read 0 and ignore writes.
REQ-028 Write to PIN_IN is ignored; unselected writes are ignored.

Reset
REQ-029 rst high at an edge: CTRL*, IRQ_*_EN, IRQ_STATUS, sync, prev = 0; sys_r_line = 32'bz; irq = 0 after that edge.
REQ-030 Reset wins over a simultaneous access; a read or write in that cycle is dropped.
REQ-031 After reset, all pins select function 0; pins are not driven unless func_dir of function 0 = 1.

Configuration
REQ-032 Macro GPIO_MATRIX_IRQ_EN defined: REQ-022..REQ-024 are implemented.
REQ-033 Macro undefined: no history flops, no enable or status registers; offsets 5..7 read 0 and ignore writes; irq is tied 0. PIN_IN still works.

Verification
REQ-034 Reset, then set func_dir function 0 = all 1 and func_out function 0 = 32'hA5A5A5A5 -> pins = 32'hA5A5A5A5; each func_in slice = 32'hA5A5A5A5.
REQ-035 Write CTRL0 = 32'h00000032 (pin0 sel 2, pin1 sel 3), with func2 and func3 pin 0/1 driving 1 -> pins[1:0] = 2'b11 one cycle after the write. Write CTRL0 = 32'h000000F0 (pin1 sel 15) -> pin1 = z.
REQ-036 Read offset 0 at edge N -> sys_r_line = last CTRL0 value at N+1. Next cycle read of an unselected address -> sys_r_line = z.
REQ-037 IRQ build: RISE_EN = 1, pins[3] 0->1 sampled at edge N -> PIN_IN[3] = 1 after N+1; IRQ_STATUS = 32'h8 and irq = 1 after N+2.
REQ-038 IRQ build: write IRQ_STATUS 32'h8 on the same edge as a new rising event on pin 3 -> bit 3 stays 1. A later write with no event clears it -> irq = 0.
REQ-039 rst asserted one cycle during a pending write of CTRL1 = 32'h11111111 -> CTRL1 reads 0; irq = 0.
